// File: rtl/alu_seq_checker.sv
// -----------------------------------------------------------------------------
// alu_seq_checker
//
// Response-side checker for the sequential byte ALU (alu_seq). It watches the
// same operand/opcode stream that drives the ALU, computes the expected
// result, delays it by the ALU's output latency and compares it with the
// ALU output every cycle. It keeps running pass/error counts and halts
// permanently (until reset) once the error limit is reached.
//
// Parameters
//   LATENCY  cycles from operand sample to ALU output valid (1..8)
//   MAX_ERR  error count that forces HALT; 0 disables halting
//   CNT_W    width of pass_cnt / err_cnt (saturating)
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous reset, active-low
//   in_valid   in   operand1/operand2/opcode form a real transaction
//   operand1   in   signed byte operand a
//   operand2   in   signed byte operand b
//   opcode     in   ADD=0 SUB=1 MULT=2 AND=3 OR=4 XOR=5 SHL=6 SHR=7
//   dut_out    in   ALU result under test
//   exp_out    out  expected value compared this cycle (0 when idle)
//   chk_valid  out  a comparison happens this cycle
//   mismatch   out  comparison failed this cycle (one-cycle pulse)
//   pass_cnt   out  matching comparisons, saturating
//   err_cnt    out  mismatching comparisons, saturating
//   halted     out  sticky, checker is in HALT
// -----------------------------------------------------------------------------
module alu_seq_checker #(
  parameter int LATENCY = 1,
  parameter int MAX_ERR = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       operand1,
  input  logic [7:0]       operand2,
  input  logic [2:0]       opcode,
  input  logic [7:0]       dut_out,
  output logic [7:0]       exp_out,
  output logic             chk_valid,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam bit             HALT_EN   = (MAX_ERR != 0);
  // One extra bit so a limit just above the counter range never matches.
  localparam logic [CNT_W:0] MAX_ERR_W = (CNT_W + 1)'(MAX_ERR);

  // Reference ALU: 8-bit two's complement, every result wraps to a byte.
  function automatic logic signed [7:0] f_alu_model(
    input logic signed [7:0] a,
    input logic signed [7:0] b,
    input logic [2:0]        op
  );
    logic signed [15:0] prod;
    logic signed [7:0]  res;
    prod = 16'(a) * 16'(b);
    res  = '0;
    case (op)
      3'd0: res = a + b;
      3'd1: res = a - b;
      3'd2: res = prod[7:0];
      3'd3: res = a & b;
      3'd4: res = a | b;
      3'd5: res = a ^ b;
      3'd6: res = a <<< b[2:0];
      3'd7: res = a >>> b[2:0];
    endcase
    return res;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic signed [7:0]       r_exp_p [LATENCY];
  logic [LATENCY-1:0]      r_vld_p;
  logic [CNT_W-1:0]        r_pass_cnt;
  logic [CNT_W-1:0]        r_err_cnt;
  logic [CNT_W-1:0]        w_err_nxt;
  logic signed [7:0]       w_op1;
  logic signed [7:0]       w_op2;
  logic signed [7:0]       w_exp_in;
  logic                    w_accept;
  logic                    w_halt_now;
  logic                    w_cmp_vld;
  logic [7:0]              w_cmp_exp;
  logic                    w_cmp_bad;

  assign w_op1     = operand1;
  assign w_op2     = operand2;
  assign w_exp_in  = f_alu_model(w_op1, w_op2, opcode);
  assign w_err_nxt = f_sat_inc(r_err_cnt);
  assign pass_cnt  = r_pass_cnt;
  assign err_cnt   = r_err_cnt;

  // ---- stage p0 .. p(LATENCY-1): expected value pipeline (data, no reset)
  always_ff @(posedge clk) begin
    r_exp_p[0] <= w_exp_in;
    for (int i = 1; i < LATENCY; i++) begin
      r_exp_p[i] <= r_exp_p[i-1];
    end
  end

  // ---- stage p0 .. p(LATENCY-1): valid pipeline (control, reset)
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= w_accept;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
      end
    end
  end

  // ---- stage LATENCY: compare and count
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pass_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (w_cmp_vld) begin
      if (w_cmp_bad) begin
        r_err_cnt <= w_err_nxt;
      end else begin
        r_pass_cnt <= f_sat_inc(r_pass_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_halt_now  = 1'b0;
    w_cmp_vld   = 1'b0;
    w_cmp_exp   = '0;
    w_cmp_bad   = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Pipeline is empty here, so there is nothing to compare yet.
        w_accept = in_valid;
        if (in_valid) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_cmp_vld = r_vld_p[LATENCY-1];
        if (w_cmp_vld) begin
          w_cmp_exp = r_exp_p[LATENCY-1];
        end
        // 4-state compare: an X/Z response is an error, not a silent pass.
        w_cmp_bad  = w_cmp_vld && (dut_out !== w_cmp_exp);
        w_halt_now = HALT_EN && w_cmp_bad && ({1'b0, w_err_nxt} == MAX_ERR_W);
        // A transaction arriving on the halting edge is dropped.
        w_accept   = in_valid && !w_halt_now;
        if (w_halt_now) begin
          w_state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign exp_out   = w_cmp_exp;
  assign chk_valid = w_cmp_vld;
  assign mismatch  = w_cmp_bad;

endmodule
